// File: rtl/ram_read_responder_if.sv
// rtl/ram_read_responder_if.sv - request/response handshake bundle for ram_read_responder
//
// Purpose: groups the read-request and read-response handshakes between an
// address-issuing initiator (master) and the RAM responder (slave).
// Signals:
//   req_valid  master->slave  read request present
//   req_ready  slave->master  responder can accept a request
//   req_addr   master->slave  read address (ADDR_WIDTH)
//   req_signed master->slave  1 = sign-extend, 0 = zero-extend
//   rsp_valid  slave->master  response FIFO head valid
//   rsp_ready  master->slave  consumer takes head
//   rsp_data   slave->master  extended read data (OUT_WIDTH)
//   rsp_err    slave->master  head came from an out-of-range address
interface ram_read_responder_if #(
  parameter int ADDR_WIDTH = 2,
  parameter int OUT_WIDTH  = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  req_signed;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [OUT_WIDTH-1:0]  rsp_data;
  logic                  rsp_err;

  modport master (
    output req_valid, req_addr, req_signed, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_signed, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
  );
endinterface

// File: rtl/ram_read_responder.sv
// rtl/ram_read_responder.sv - small RAM with handshaked reads and a 2-entry response FIFO
//
// Purpose: DEPTH x DATA_WIDTH memory with one write port. Read requests are
// accepted over bus.req_*, read at the accepting edge, extended to OUT_WIDTH
// and pushed into a 2-entry response FIFO drained over bus.rsp_*.
// Optional feature macro: RAM_READ_BYPASS_EN (same-cycle write-to-read forwarding).
// Ports:
//   i_clk       clock, all state on rising edge
//   i_rst_n     asynchronous active-low reset (memory contents unaffected)
//   i_wr_en     write strobe
//   i_wr_addr   write address, ignored when >= DEPTH
//   i_wr_data   write data
//   bus         ram_read_responder_if.slave request/response handshakes
//   o_rd_count  accepted-request counter, wraps at 16 bits
module ram_read_responder #(
  parameter int ADDR_WIDTH = 2,
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int OUT_WIDTH  = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  ram_read_responder_if.slave   bus,
  output logic [15:0]           o_rd_count
);

  // ---------------------------------------------------------------------
  // Memory: one register per word, power-up value = word index. Not reset.
  // ---------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] w_words [DEPTH];

  for (genvar g = 0; g < DEPTH; g++) begin : g_mem
    logic [DATA_WIDTH-1:0] r_word = DATA_WIDTH'(g);

    always_ff @(posedge i_clk) begin
      if (i_wr_en && (i_wr_addr == ADDR_WIDTH'(g))) begin
        r_word <= i_wr_data;
      end
    end

    assign w_words[g] = r_word;
  end

  // ---------------------------------------------------------------------
  // Read path: address decode doubles as the range check, so an address
  // >= DEPTH never indexes the array.
  // ---------------------------------------------------------------------
  logic                  w_in_range;
  logic [DATA_WIDTH-1:0] w_rd_word;
  logic [OUT_WIDTH-1:0]  w_ext;

  always_comb begin
    w_in_range = 1'b0;
    w_rd_word  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (bus.req_addr == ADDR_WIDTH'(i)) begin
        w_in_range = 1'b1;
        w_rd_word  = w_words[i];
      end
    end
`ifdef RAM_READ_BYPASS_EN
    // Forward the word being written this edge to a read of the same address.
    if (w_in_range && i_wr_en && (i_wr_addr == bus.req_addr)) begin
      w_rd_word = i_wr_data;
    end
`else
    // Read-before-write: the stored word is returned, the write still lands.
`endif
  end

  always_comb begin
    w_ext = OUT_WIDTH'(w_rd_word);
    if (bus.req_signed) begin
      for (int i = DATA_WIDTH; i < OUT_WIDTH; i++) begin
        w_ext[i] = w_rd_word[DATA_WIDTH-1];
      end
    end
    if (!w_in_range) begin
      w_ext = '0;
    end
  end

  // ---------------------------------------------------------------------
  // Response FIFO, 2 entries. req_ready depends only on r_cnt, so a pop in
  // the same cycle as a full FIFO frees the slot only for the next cycle.
  // ---------------------------------------------------------------------
  logic [1:0]           r_cnt;
  logic                 r_wr_ptr;
  logic                 r_rd_ptr;
  logic [OUT_WIDTH-1:0] r_fifo_data [2];
  logic                 r_fifo_err  [2];
  logic [15:0]          r_rd_count;
  logic                 w_push;
  logic                 w_pop;

  assign w_push = bus.req_valid & bus.req_ready;
  assign w_pop  = bus.rsp_valid & bus.rsp_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt      <= 2'd0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_rd_count <= 16'd0;
      for (int i = 0; i < 2; i++) begin
        r_fifo_data[i] <= '0;
        r_fifo_err[i]  <= 1'b0;
      end
    end else begin
      if (w_push) begin
        r_fifo_data[r_wr_ptr] <= w_ext;
        r_fifo_err[r_wr_ptr]  <= ~w_in_range;
        r_wr_ptr              <= ~r_wr_ptr;
        r_rd_count            <= r_rd_count + 16'd1;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign bus.req_ready = (r_cnt != 2'd2);
  assign bus.rsp_valid = (r_cnt != 2'd0);
  assign bus.rsp_data  = r_fifo_data[r_rd_ptr];
  assign bus.rsp_err   = r_fifo_err[r_rd_ptr];
  assign o_rd_count    = r_rd_count;

endmodule
